// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and baud defaults.
// Used by the receiver here and by the existing transmit path.
package uart_pkg;

   localparam int UART_DATA_W      = 8;
   localparam int UART_MIN_DIV     = 4;
   localparam int UART_DEF_CLK_DIV = 4167;

   typedef logic [2:0] uart_state_t;

   localparam uart_state_t ST_IDLE   = 3'd0;
   localparam uart_state_t ST_START  = 3'd1;
   localparam uart_state_t ST_DATA   = 3'd2;
   localparam uart_state_t ST_PARITY = 3'd3;
   localparam uart_state_t ST_STOP   = 3'd4;

   // 0 selects the build default; anything below the minimum is clamped up.
   function automatic logic [15:0] uart_eff_div(input logic [15:0] div,
                                                input logic [15:0] def_div);
      if (div == 16'd0)
         return def_div;
      else if (div < 16'(UART_MIN_DIV))
         return 16'(UART_MIN_DIV);
      else
         return div;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; DEPTH must be a power of two >= 2.
// A push on a full FIFO is accepted only when a pop happens on the same cycle.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = UART_DATA_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        head,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign level   = wr_ptr - rd_ptr;
   assign empty   = (level == '0);
   assign full    = (level == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // NOTE: storage is not reset; the pointers define validity and head is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised input, mid-bit sampling FSM and FWFT byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity check; default is 8N1.
module uart_rx
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int DEF_CLK_DIV = UART_DEF_CLK_DIV
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   input  logic                         rx_i,
   input  logic [15:0]                  clk_div,
   output logic [UART_DATA_W-1:0]       rx_data,
   output logic                         rx_valid,
   input  logic                         rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]  rx_level,
   output logic                         rx_busy,
   output logic                         frame_err,
   output logic                         overrun,
   output logic                         parity_err
);

   uart_state_t            state;
   uart_state_t            state_nxt;
   logic                   rx_meta;
   logic                   rx_sync;
   logic                   rx_last;
   logic [15:0]            eff_div;
   logic [15:0]            div_q;
   logic [15:0]            cnt;
   logic [2:0]             idx;
   logic [UART_DATA_W-1:0] shreg;
   logic                   start_edge;
   logic                   expire;
   logic                   par_bad;
   logic                   push_stb;
   logic                   frame_stb;
   logic                   over_stb;
   logic                   par_stb;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   pop;

   assign eff_div    = uart_eff_div(clk_div, 16'(DEF_CLK_DIV));
   assign start_edge = rx_last && !rx_sync;
   assign expire     = (cnt <= 16'd1);
   assign rx_valid   = !fifo_empty;
   assign pop        = rx_valid && rx_ready;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_last <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_sync <= rx_meta;
         rx_last <= rx_sync;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (start_edge) state_nxt = ST_START;
         ST_START: if (expire) state_nxt = rx_sync ? ST_IDLE : ST_DATA;
         ST_DATA: begin
            if (expire && idx == 3'(UART_DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
               state_nxt = ST_PARITY;
`else
               state_nxt = ST_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: if (expire) state_nxt = ST_PARITY + 3'd1;
`endif
         ST_STOP:  if (expire) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Stop-bit outcome: one result per frame, parity beats framing beats overrun.
   always_comb begin
      rx_busy   = (state != ST_IDLE);
      push_stb  = 1'b0;
      frame_stb = 1'b0;
      over_stb  = 1'b0;
      par_stb   = 1'b0;
      if (state == ST_STOP && expire) begin
         if (par_bad)                  par_stb   = 1'b1;
         else if (!rx_sync)            frame_stb = 1'b1;
         else if (fifo_full && !pop)   over_stb  = 1'b1;
         else                          push_stb  = 1'b1;
      end
   end

   // Divider is latched at the start edge so clk_div changes only affect later frames.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         div_q <= '0;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else if (state == ST_IDLE) begin
         if (start_edge) begin
            div_q <= eff_div;
            cnt   <= eff_div >> 1;
            idx   <= '0;
         end
      end else if (expire) begin
         cnt <= div_q;
         if (state == ST_DATA) begin
            shreg <= {rx_sync, shreg[UART_DATA_W-1:1]};
            idx   <= idx + 3'd1;
         end
      end else begin
         cnt <= cnt - 16'd1;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bit;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)                           par_bit <= 1'b0;
      else if (state == ST_PARITY && expire)  par_bit <= rx_sync;
   end

   assign par_bad = ^{shreg, par_bit};
`else
   assign par_bad = 1'b0;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         frame_err  <= frame_stb;
         overrun    <= over_stb;
         parity_err <= par_stb;
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_W)
   ) u_fifo (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .push      (push_stb),
      .push_data (shreg),
      .pop       (pop),
      .head      (rx_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (rx_level)
   );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: tbuart-style frame driver, queue-based byte/pulse
// model and a per-cycle compare process. Honours UART_RX_PARITY_EN like the RTL.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic          clk      = 1'b0;
   logic          rst      = 1'b1;
   logic          rx_i     = 1'b1;
   logic          rx_ready = 1'b0;
   logic [15:0]   clk_div  = 16'd16;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [LW-1:0] rx_level;
   logic          rx_busy;
   logic          frame_err;
   logic          overrun;
   logic          parity_err;

   uart_rx #(.FIFO_DEPTH(DEPTH), .DEF_CLK_DIV(4167)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .rx_i       (rx_i),
      .clk_div    (clk_div),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .rx_level   (rx_level),
      .rx_busy    (rx_busy),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   always #12.5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: bytes that must come out, in order, plus expected pulse counts.
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int         lat_start_q[$];
   int         lat_exp_q[$];
   int         exp_frame = 0, exp_over = 0, exp_par = 0;
   int         act_frame = 0, act_over = 0, act_par = 0;
   bit         lat_en     = 1'b0;
   bit         rand_ready = 1'b0;
   bit         seen_busy  = 1'b0;
   logic       fe_prev = 1'b0, ov_prev = 1'b0, pe_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int bit_len(input logic [15:0] div);
      if (div == 16'd0)     return 4167;
      else if (div < 16'd4) return 4;
      else                  return int'(div);
   endfunction

   task automatic idle(input int n);
      rx_i = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Predict the frame's fate from the framing rules, then drive it bit by bit.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip,
                             input int mid_div);
      int n;
      n = bit_len(clk_div);
      if (PAR_EN && par_flip) exp_par++;
      else if (!stop_ok) exp_frame++;
      else if (exp_q.size() >= DEPTH) exp_over++;
      else begin
         exp_q.push_back(b);
         if (lat_en) begin
            lat_start_q.push_back(cyc);
            lat_exp_q.push_back(3 + n / 2 + (PAR_EN ? 10 : 9) * n);
         end
      end
      rx_i = 1'b0;
      repeat (n) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         if (i == 3 && mid_div >= 0) clk_div = 16'(mid_div);
         rx_i = b[i];
         repeat (n) @(negedge clk);
      end
      if (PAR_EN) begin
         rx_i = (^b) ^ par_flip;
         repeat (n) @(negedge clk);
      end
      rx_i = stop_ok;
      repeat (n) @(negedge clk);
      rx_i = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || rx_valid) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("drain_in_time", k < budget, 1);
   endtask

   task automatic got_at(input string name, input int i, input logic [7:0] v);
      check(name, (i < got_q.size()) ? 32'(got_q[i]) : 32'h1FF, 32'(v));
   endtask

   // Consumer-side compare process, sampled just after the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            if (rx_busy) seen_busy = 1'b1;
            check("valid_vs_level", rx_valid, rx_level != '0);
            check("level_max", rx_level <= LW'(DEPTH), 1);
            check("pulse_exclusive",
                  (32'(frame_err) + 32'(overrun) + 32'(parity_err)) <= 32'd1, 1);
            check("frame_err_width", frame_err & fe_prev, 0);
            check("overrun_width", overrun & ov_prev, 0);
            check("parity_err_width", parity_err & pe_prev, 0);
            if (frame_err)  act_frame++;
            if (overrun)    act_over++;
            if (parity_err) act_par++;
            if (rx_valid && rx_ready) begin
               got_q.push_back(rx_data);
               check("byte_pending", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) check("rx_data", rx_data, exp_q.pop_front());
               if (lat_en && lat_start_q.size() != 0)
                  check("push_latency", cyc - lat_start_q.pop_front(), lat_exp_q.pop_front());
            end
         end
         fe_prev = frame_err;
         ov_prev = overrun;
         pe_prev = parity_err;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #(150000 * 25);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   logic [7:0] t1 [4] = '{8'h0F, 8'h3D, 8'h10, 8'h33};

   initial begin
      logic [7:0] b;
      bit         ok;
      int         d;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid", rx_valid, 0);
      check("rst_busy", rx_busy, 0);
      check("rst_level", rx_level, 0);
      check("rst_data", rx_data, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_overrun", overrun, 0);
      check("rst_parity_err", parity_err, 0);
      rst = 1'b0;
      idle(20);

      // Back-to-back bytes, consumer always ready.
      rx_ready = 1'b1;
      lat_en   = 1'b1;
      foreach (t1[i]) send_frame(t1[i], 1'b1, 1'b0, -1);
      idle(48);
      wait_drain(200);
      lat_en = 1'b0;
      check("t1_count", got_q.size(), 4);
      foreach (t1[i]) got_at("t1_byte", i, t1[i]);
      check("t1_no_pulses", act_frame + act_over + act_par, 0);

      // Fill with consumer stalled: fifth byte overruns.
      got_q.delete();
      rx_ready = 1'b0;
      for (int i = 0; i < 5; i++) send_frame(8'(8'h0F + i), 1'b1, 1'b0, -1);
      idle(32);
      check("t2_level_full", rx_level, 4);
      check("t2_level_model", rx_level, exp_q.size());
      check("t2_overrun_once", act_over, 1);
      rx_ready = 1'b1;
      wait_drain(50);
      check("t2_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++) got_at("t2_byte", i, 8'(8'h0F + i));

      // Stop bit low: frame error, then a clean byte.
      got_q.delete();
      send_frame(8'hA5, 1'b0, 1'b0, -1);
      idle(32);
      check("t3_frame_err_once", act_frame, 1);
      check("t3_level", rx_level, 0);
      send_frame(8'h5A, 1'b1, 1'b0, -1);
      idle(32);
      wait_drain(50);
      check("t3_count", got_q.size(), 1);
      got_at("t3_byte", 0, 8'h5A);

      // Short low glitch on an idle line.
      seen_busy = 1'b0;
      rx_i = 1'b0;
      repeat (4) @(negedge clk);
      rx_i = 1'b1;
      repeat (9) @(negedge clk);
      check("t4_busy_cleared", rx_busy, 0);
      check("t4_busy_seen", seen_busy, 1);
      check("t4_level", rx_level, 0);

      // Reset in the middle of data bit 4 of 0x3D with one byte already buffered.
      got_q.delete();
      rx_ready = 1'b0;
      send_frame(8'h10, 1'b1, 1'b0, -1);
      idle(32);
      check("t5_level_before", rx_level, 1);
      b = 8'h3D;
      rx_i = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx_i = b[i];
         repeat (16) @(negedge clk);
      end
      rx_i = b[4];
      repeat (8) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("t5_level_after", rx_level, 0);
      check("t5_valid_after", rx_valid, 0);
      check("t5_busy_after", rx_busy, 0);
      idle(12 * 16);
      check("t5_still_empty", rx_level, 0);
      rx_ready = 1'b1;
      send_frame(8'h33, 1'b1, 1'b0, -1);
      idle(32);
      wait_drain(50);
      check("t5_count", got_q.size(), 1);
      got_at("t5_byte", 0, 8'h33);

      // clk_div changed mid-frame only applies to the next frame.
      got_q.delete();
      clk_div = 16'd16;
      send_frame(8'h96, 1'b1, 1'b0, 7);
      idle(20);
      send_frame(8'h69, 1'b1, 1'b0, -1);
      idle(20);
      wait_drain(50);
      got_at("t6_byte0", 0, 8'h96);
      got_at("t6_byte1", 1, 8'h69);

      // clk_div below the minimum clamps to 4 clocks per bit.
      got_q.delete();
      lat_en  = 1'b1;
      clk_div = 16'd2;
      send_frame(8'hC3, 1'b1, 1'b0, -1);
      idle(12);
      wait_drain(50);
      got_at("t7_byte", 0, 8'hC3);

      // Randomised frames, dividers 1..24, occasional bad stop bits, ready held high.
      for (int f = 0; f < 30; f++) begin
         clk_div = 16'($urandom_range(1, 24));
         d  = bit_len(clk_div);
         b  = 8'($urandom);
         ok = ($urandom_range(0, 7) != 0);
         send_frame(b, ok, PAR_EN && ($urandom_range(0, 7) == 0), -1);
         idle(d * (ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2))));
      end
      idle(60);
      wait_drain(200);
      lat_en = 1'b0;

      // Randomised frames with a randomly stalling consumer.
      rand_ready = 1'b1;
      for (int f = 0; f < 20; f++) begin
         clk_div = 16'($urandom_range(4, 12));
         send_frame(8'($urandom), 1'b1, 1'b0, -1);
         idle(int'($urandom_range(0, 12)));
      end
      rand_ready = 1'b0;
      @(negedge clk);
      rx_ready = 1'b1;
      idle(40);
      wait_drain(200);

`ifdef UART_RX_PARITY_EN
      // Even parity bit for 0x07 is 1; sending 0 must drop the byte.
      clk_div = 16'd16;
      d = act_par;
      send_frame(8'h07, 1'b1, 1'b1, -1);
      idle(32);
      check("t_par_pulse", act_par - d, 1);
      check("t_par_level", rx_level, 0);
`endif

      // Default divider (clk_div=0): 4167 clocks per bit.
      got_q.delete();
      lat_en  = 1'b1;
      clk_div = 16'd0;
      send_frame(8'h55, 1'b1, 1'b0, -1);
      idle(40);
      wait_drain(100);
      got_at("t9_byte", 0, 8'h55);
      lat_en = 1'b0;

      idle(20);
      check("final_frame_err", act_frame, exp_frame);
      check("final_overrun", act_over, exp_over);
      check("final_parity_err", act_par, exp_par);
      check("final_model_empty", exp_q.size(), 0);
      check("final_level", rx_level, 0);
      check("final_busy", rx_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
